// File: rtl/nn_seq_pkg.sv
// nn_seq_pkg: sequencer states, descriptor layout offsets and default neuron bank bases
package nn_seq_pkg;
  typedef enum logic [3:0] {
    IDLE, FETCH_L, FETCH_NK, FETCH_NN, CONFIG, RUN, DRAIN, NEXT, PAUSE, DONE
  } seq_state_e;
  localparam int LAYER_CNT_OFS = 0;
  localparam int LAYER_WORDS   = 2;
  localparam int BANK_A_DEF    = 0;
  localparam int BANK_B_DEF    = 10;
endpackage

// File: rtl/pulse_delay.sv
// pulse_delay: DEPTH-stage shift register delaying a single-cycle pulse, with synchronous clear
module pulse_delay #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic d_i,
  output logic q_o
);
  logic [DEPTH-1:0] sr_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sr_q <= '0;
    else sr_q <= clr_i ? '0 : (sr_q << 1) | DEPTH'(d_i);
  assign q_o = sr_q[DEPTH-1];
endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: descriptor-driven layer scheduler for AG, weight ROM, neuron RAM and MAC.
// Optional SEQ_SINGLE_STEP_EN adds step/paused and a PAUSE state between layers.
module layer_sequencer
  import nn_seq_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int BANK_A  = BANK_A_DEF,
  parameter int BANK_B  = BANK_B_DEF,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
`ifdef SEQ_SINGLE_STEP_EN
  input  logic              step,
  output logic              paused,
`endif
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [DATA_W-1:0] instr_data,
  input  logic              ag_neuron_finished,
  input  logic              ag_finished,
  output logic              ag_rst,
  output logic              ag_read,
  output logic [DATA_W-1:0] nk,
  output logic [ADDR_W-1:0] weight_read_base,
  output logic [ADDR_W-1:0] neuro_read_base,
  output logic [ADDR_W-1:0] neuro_write_base,
  output logic              mac_rst,
  output logic              mac_forget,
  output logic              ram_wre,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] layer_idx,
  output logic              busy,
  output logic              done
);
  localparam logic [ADDR_W-1:0] A1 = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] BA = ADDR_W'(BANK_A);
  localparam logic [ADDR_W-1:0] BB = ADDR_W'(BANK_B);
  seq_state_e state_q, state_d;
  logic [ADDR_W-1:0] ia_q, ia_d, wb_q, wb_d, rb_q, rb_d, wrb_q, wrb_d, wa_q, wa_d;
  logic [DATA_W-1:0] l_q, l_d, nk_q, nk_d, nn_q, nn_d, li_q, li_d;
  logic [2:0] cnt_q, cnt_d;
  logic last, wre;
  // Only reads inside RUN feed the write pipeline; CONFIG flushes anything stale.
  pulse_delay #(.DEPTH(MAC_LAT)) u_dly (
    .clk(clk), .rst_n(reset), .clr_i(state_q == CONFIG),
    .d_i(ag_neuron_finished & (state_q == RUN)), .q_o(wre)
  );
  assign last = li_q + DATA_W'(1) == l_q;
  always_comb begin
    state_d = state_q;
    ia_d = ia_q;
    l_d = l_q;
    nk_d = nk_q;
    nn_d = nn_q;
    wb_d = wb_q;
    rb_d = rb_q;
    wrb_d = wrb_q;
    wa_d = wre ? wa_q + A1 : wa_q;
    li_d = li_q;
    cnt_d = cnt_q + 3'd1;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH_L;
        ia_d = ADDR_W'(LAYER_CNT_OFS);
        nk_d = '0;
        wb_d = '0;
        rb_d = BA;
        wrb_d = BB;
        wa_d = BB;
        li_d = '0;
      end
      FETCH_L: begin
        l_d = instr_data;
        state_d = instr_data == '0 ? DONE : FETCH_NK;
        ia_d = instr_data == '0 ? ia_q : ADDR_W'(LAYER_CNT_OFS + 1);
      end
      FETCH_NK: begin
        nk_d = instr_data;
        ia_d = ia_q + A1;
        state_d = FETCH_NN;
      end
      FETCH_NN: begin
        nn_d = instr_data;
        state_d = (nk_q == '0 || instr_data == '0) ? NEXT : CONFIG;
      end
      CONFIG: begin
        wa_d = wrb_q;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = '0;
        state_d = ag_finished ? DRAIN : RUN;
      end
      DRAIN: state_d = cnt_q == 3'(MAC_LAT) ? NEXT : DRAIN;
      NEXT: begin
        wb_d = wb_q + ADDR_W'(nk_q) * ADDR_W'(nn_q);
        rb_d = wrb_q;
        wrb_d = rb_q;
        ia_d = ia_q + ADDR_W'(LAYER_WORDS - 1);
        li_d = last ? li_q : li_q + DATA_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
        state_d = last ? DONE : PAUSE;
`else
        state_d = last ? DONE : FETCH_NK;
`endif
      end
`ifdef SEQ_SINGLE_STEP_EN
      PAUSE: state_d = step ? FETCH_NK : PAUSE;
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q <= IDLE;
      ia_q <= '0;
      l_q <= '0;
      nk_q <= '0;
      nn_q <= '0;
      wb_q <= '0;
      rb_q <= BA;
      wrb_q <= BB;
      wa_q <= BB;
      li_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      ia_q <= ia_d;
      l_q <= l_d;
      nk_q <= nk_d;
      nn_q <= nn_d;
      wb_q <= wb_d;
      rb_q <= rb_d;
      wrb_q <= wrb_d;
      wa_q <= wa_d;
      li_q <= li_d;
      cnt_q <= cnt_d;
    end
  assign instr_addr = ia_q;
  assign nk = nk_q;
  assign weight_read_base = wb_q;
  assign neuro_read_base = rb_q;
  assign neuro_write_base = wrb_q;
  assign ram_wr_addr = wa_q;
  assign layer_idx = li_q;
  assign ag_rst = state_q != RUN;
  assign ag_read = state_q == RUN;
  assign mac_rst = !(state_q == RUN || state_q == DRAIN);
  assign mac_forget = wre;
  assign ram_wre = wre;
  assign busy = !(state_q == IDLE || state_q == DONE);
  assign done = state_q == DONE;
`ifdef SEQ_SINGLE_STEP_EN
  assign paused = state_q == PAUSE;
`endif
endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed and random descriptors against an AG model and a layer-level reference model
module tb_layer_sequencer;
  localparam int AW = 8, DW = 8, LAT = 2;
  typedef struct {int nk; int nn; int rb; int wb; int w; int li;} lay_t;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, ag_nf = 1'b0, ag_f = 1'b0;
  logic [AW-1:0] instr_addr, wbase, rbase, wrbase, wr_addr;
  logic [DW-1:0] instr_data, nk, layer_idx;
  logic ag_rst, ag_read, mac_rst, mac_forget, ram_wre, busy, done, prev_ag_rst;
  logic [DW-1:0] mem [256];
  lay_t ex[$];
  int wq[$], nfq[$], d[$];
  int checks = 0, errors = 0, cyc = 0;
  int run_idx, cnt, reads, wres, dones, pauses, t_start, t_done;
  int exp_l, exp_w, exp_rb, exp_wb, exp_li, exp_nw, exp_reads;
`ifdef SEQ_SINGLE_STEP_EN
  logic step = 1'b0, paused;
`endif
  always #5 clk = ~clk;
  assign instr_data = mem[instr_addr];
  layer_sequencer dut (
    .clk(clk), .reset(reset), .start(start),
`ifdef SEQ_SINGLE_STEP_EN
    .step(step), .paused(paused),
`endif
    .instr_addr(instr_addr), .instr_data(instr_data),
    .ag_neuron_finished(ag_nf), .ag_finished(ag_f), .ag_rst(ag_rst), .ag_read(ag_read),
    .nk(nk), .weight_read_base(wbase), .neuro_read_base(rbase), .neuro_write_base(wrbase),
    .mac_rst(mac_rst), .mac_forget(mac_forget), .ram_wre(ram_wre), .ram_wr_addr(wr_addr),
    .layer_idx(layer_idx), .busy(busy), .done(done)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic chk_rst(input string tag);
    chk(tag, {busy, done, ag_rst, mac_rst, ag_read, mac_forget, ram_wre}, 7'b0011000);
    chk({tag, "_bases"}, {instr_addr, nk, wbase, rbase}, 32'h0);
    chk({tag, "_wr"}, {wrbase, wr_addr, layer_idx}, {8'd10, 8'd10, 8'd0});
  endtask
  // Reference: walk the layer list arithmetically, banks swap every layer, skipped layers write nothing.
  task automatic build(input int l, input int dq[$]);
    foreach (mem[i]) mem[i] = DW'($urandom);
    mem[0] = DW'(l);
    ex.delete(); wq.delete(); nfq.delete();
    exp_l = l; exp_w = 0; exp_rb = 0; exp_wb = 10; exp_li = 0; exp_nw = 0; exp_reads = 0;
    for (int i = 0; i < l; i++) begin
      int k, n, t;
      k = dq[2*i]; n = dq[2*i+1];
      mem[1+2*i] = DW'(k); mem[2+2*i] = DW'(n);
      if (k > 0 && n > 0) begin
        ex.push_back('{k, n, exp_rb, exp_wb, exp_w, exp_li});
        for (int j = 0; j < n; j++) wq.push_back((exp_wb + j) % 256);
        exp_nw += n; exp_reads += k * n;
      end
      exp_w = (exp_w + k * n) % 256;
      t = exp_rb; exp_rb = exp_wb; exp_wb = t;
      if (i + 1 < l) exp_li = i + 1;
    end
  endtask
  // One cycle: observe outputs mid-cycle, then drive the AG model's response for this cycle.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (ram_wre || mac_forget) begin
      wres++;
      chk("forget_eq_wre", mac_forget, ram_wre);
      chk("wre_expected", wq.size() > 0, 1);
      if (wq.size() > 0) chk("wr_addr", wr_addr, wq.pop_front());
      chk("nf_pending", nfq.size() > 0, 1);
      if (nfq.size() > 0) chk("wre_latency", cyc - nfq.pop_front(), LAT);
    end
    if (done) dones++;
    if (ag_read) reads++;
    if (!ag_rst && prev_ag_rst) begin
      run_idx++; cnt = 0;
      chk("run_known", run_idx < ex.size(), 1);
      if (run_idx < ex.size()) begin
        chk("run_nk", nk, ex[run_idx].nk);
        chk("run_wbase", wbase, ex[run_idx].w);
        chk("run_rbase", rbase, ex[run_idx].rb);
        chk("run_wrbase", wrbase, ex[run_idx].wb);
        chk("run_layer", layer_idx, ex[run_idx].li);
      end
    end
    prev_ag_rst = ag_rst;
    ag_nf = 1'b0; ag_f = 1'b0;
    if (ag_read && !ag_rst && run_idx >= 0 && run_idx < ex.size()) begin
      cnt++;
      ag_nf = cnt % ex[run_idx].nk == 0;
      ag_f = cnt == ex[run_idx].nk * ex[run_idx].nn;
      if (ag_nf) nfq.push_back(cyc);
    end else if (!ag_read) ag_nf = $urandom_range(0, 3) == 0;
  endtask
  task automatic go();
    run_idx = -1; cnt = 0; reads = 0; wres = 0; dones = 0; pauses = 0; prev_ag_rst = 1'b1;
    t_start = cyc;
    start = 1'b1; tick(); start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask
  task automatic run_case();
    go();
    while (!done && cyc - t_start < 3000) begin
`ifdef SEQ_SINGLE_STEP_EN
      if (paused) begin
        pauses++;
        repeat (20) begin chk("pause_hold", {paused, ag_read}, 2'b10); tick(); end
        step = 1'b1; tick(); step = 1'b0;
      end else
`endif
      tick();
    end
    t_done = cyc;
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    chk("wbase_final", wbase, exp_w);
    chk("rbase_final", rbase, exp_rb);
    chk("wrbase_final", wrbase, exp_wb);
    chk("layer_final", layer_idx, exp_li);
    repeat (4) tick();
    chk("done_once", dones, 1);
    chk("wre_total", wres, exp_nw);
    chk("writes_left", wq.size(), 0);
    chk("runs", run_idx + 1, ex.size());
    chk("reads", reads, exp_reads);
    chk("idle_after", {busy, ag_read}, 2'b00);
`ifdef SEQ_SINGLE_STEP_EN
    chk("pauses", pauses, exp_l > 0 ? exp_l - 1 : 0);
`endif
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_rst("reset");
    reset = 1'b1;
    tick();
    d = {3, 2}; build(1, d); run_case();
    d = {3, 2, 2, 1}; build(2, d); run_case();
    d = {}; build(0, d); run_case();
    chk("l0_done_lat", t_done - t_start, 2);
    d = {3, 0, 2, 2}; build(2, d); run_case();
    d = {0, 4, 2, 3, 1, 1}; build(3, d); run_case();
    repeat (6) begin
      int l;
      l = $urandom_range(1, 4);
      d.delete();
      repeat (2 * l) d.push_back($urandom_range(0, 4));
      build(l, d); run_case();
    end
    d = {3, 2}; build(1, d); go();
    while (nfq.size() == 0 && cyc - t_start < 200) tick();
    chk("mid_nf_seen", nfq.size(), 1);
    tick();
    reset = 1'b0;
    #1;
    chk_rst("rst_mid");
    wq.delete(); nfq.delete();
    repeat (4) tick();
    chk_rst("rst_hold");
    reset = 1'b1;
    repeat (2) tick();
    chk("idle_after_rst", busy, 0);
    build(1, d); run_case();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
